fifo_ctrl_mc: RTL and testbench

Multi-channel FIFO pointer and status controller, generalising single-channel read-side logic to NUM_CH independent channels.
Each channel has its own write pointer, read pointer, occupancy count, empty/full and almost-empty/almost-full flags, and sticky overflow/underflow errors.
Sits between per-channel producer/consumer request logic and a banked dual-port memory; push/pop strobes and pointers drive the memory directly.
Non-power-of-two depths are supported.

---
 rtl/fifo_ctrl_mc.sv | 160 ++++++++++++++++
 tb/tb_fifo_ctrl_mc.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl_mc.sv
// ---------------------------------------------------------------------------
// fifo_ctrl_mc
//
// Pointer and status controller for NUM_CH independent FIFOs that share a
// banked dual-port memory. Each channel keeps its own write/read pointer,
// occupancy count, status flags and sticky error bits. Accept strobes are
// combinational so the memory can write at wr_ptr / read at rd_ptr in the
// same cycle the request is granted. Non-power-of-two depths are supported.
//
// Parameters
//   NUM_CH    number of independent channels
//   MEM_SIZE  entries per channel (>= 2)
//   WORD_SIZE data width of the attached memory (no data path here)
//   PTR_L     pointer width, 2**PTR_L >= MEM_SIZE
//   CNT_L     count width,   2**CNT_L >  MEM_SIZE
//
// Ports (channel c always uses bit c / slice c of every vector)
//   clk, reset_L        clock (rising edge), async active-low reset
//   fifo_wr, fifo_rd    per-channel write / read requests
//   af_thr, ae_thr      shared almost-full / almost-empty thresholds
//   err_clr             clears all sticky error bits
//   push, pop           accepted write / read strobes (combinational)
//   wr_ptr, rd_ptr      pointers, channel c at [c*PTR_L +: PTR_L]
//   count               occupancy, channel c at [c*CNT_L +: CNT_L]
//   fifo_empty/full     count == 0 / count == MEM_SIZE
//   almost_empty/full   count <= ae_thr / count >= af_thr
//   err_ovf, err_udf    sticky: write rejected / read rejected
//
// Build option
//   RD_BYPASS_EN  when defined, a read on an empty channel is accepted if a
//                 write arrives in the same cycle (memory forwards the data).
// ---------------------------------------------------------------------------
module fifo_ctrl_mc #(
  parameter int NUM_CH    = 4,
  parameter int MEM_SIZE  = 4,
  parameter int WORD_SIZE = 6,
  parameter int PTR_L     = 2,
  parameter int CNT_L     = 3
) (
  input  logic                      clk,
  input  logic                      reset_L,
  input  logic [NUM_CH-1:0]         fifo_wr,
  input  logic [NUM_CH-1:0]         fifo_rd,
  input  logic [CNT_L-1:0]          af_thr,
  input  logic [CNT_L-1:0]          ae_thr,
  input  logic                      err_clr,
  output logic [NUM_CH-1:0]         push,
  output logic [NUM_CH-1:0]         pop,
  output logic [NUM_CH*PTR_L-1:0]   wr_ptr,
  output logic [NUM_CH*PTR_L-1:0]   rd_ptr,
  output logic [NUM_CH*CNT_L-1:0]   count,
  output logic [NUM_CH-1:0]         fifo_empty,
  output logic [NUM_CH-1:0]         fifo_full,
  output logic [NUM_CH-1:0]         almost_empty,
  output logic [NUM_CH-1:0]         almost_full,
  output logic [NUM_CH-1:0]         err_ovf,
  output logic [NUM_CH-1:0]         err_udf
);

  // Elaboration-time sanity checks on the sizing parameters.
  if (MEM_SIZE < 2)                $error("fifo_ctrl_mc: MEM_SIZE must be >= 2");
  if ((1 << PTR_L) < MEM_SIZE)     $error("fifo_ctrl_mc: PTR_L too small for MEM_SIZE");
  if ((1 << CNT_L) <= MEM_SIZE)    $error("fifo_ctrl_mc: CNT_L too small for MEM_SIZE");
  if (WORD_SIZE < 1)               $error("fifo_ctrl_mc: WORD_SIZE must be >= 1");

  localparam logic [PTR_L-1:0] PTR_LAST = PTR_L'(MEM_SIZE - 1);
  localparam logic [CNT_L-1:0] CNT_FULL = CNT_L'(MEM_SIZE);

  logic [NUM_CH-1:0][PTR_L-1:0] wr_ptr_q, wr_ptr_d;
  logic [NUM_CH-1:0][PTR_L-1:0] rd_ptr_q, rd_ptr_d;
  logic [NUM_CH-1:0][CNT_L-1:0] count_q,  count_d;
  logic [NUM_CH-1:0]            err_ovf_q, err_ovf_d;
  logic [NUM_CH-1:0]            err_udf_q, err_udf_d;

  logic [NUM_CH-1:0] empty_c, full_c, push_c, pop_c;

  // NOTE: every signal written here is given a default at the top of the
  // block so no path leaves it unassigned; that keeps this purely
  // combinational and prevents latch inference.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    err_ovf_d = err_clr ? '0 : err_ovf_q;
    err_udf_d = err_clr ? '0 : err_udf_q;
    empty_c   = '0;
    full_c    = '0;
    push_c    = '0;
    pop_c     = '0;

    for (int c = 0; c < NUM_CH; c++) begin
      empty_c[c] = (count_q[c] == '0);
      full_c[c]  = (count_q[c] == CNT_FULL);

      // Strobes are gated by reset_L so nothing is granted while reset is
      // held, even if requests stay active through the reset.
`ifdef RD_BYPASS_EN
      pop_c[c]  = reset_L & fifo_rd[c] & (~empty_c[c] | fifo_wr[c]);
`else
      pop_c[c]  = reset_L & fifo_rd[c] & ~empty_c[c];
`endif
      // A full channel still accepts a write when a read frees a slot.
      push_c[c] = reset_L & fifo_wr[c] & (~full_c[c] | pop_c[c]);

      if (push_c[c])
        wr_ptr_d[c] = (wr_ptr_q[c] == PTR_LAST) ? '0 : wr_ptr_q[c] + PTR_L'(1);
      if (pop_c[c])
        rd_ptr_d[c] = (rd_ptr_q[c] == PTR_LAST) ? '0 : rd_ptr_q[c] + PTR_L'(1);

      unique case ({push_c[c], pop_c[c]})
        2'b10:   count_d[c] = count_q[c] + CNT_L'(1);
        2'b01:   count_d[c] = count_q[c] - CNT_L'(1);
        default: count_d[c] = count_q[c];
      endcase

      // New errors are OR-ed after the clear so a set wins over err_clr.
      if (fifo_wr[c] & ~push_c[c]) err_ovf_d[c] = 1'b1;
      if (fifo_rd[c] & ~pop_c[c])  err_udf_d[c] = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      err_ovf_q <= '0;
      err_udf_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      err_ovf_q <= err_ovf_d;
      err_udf_q <= err_udf_d;
    end
  end

  // Flags decode the registered count, so they follow a strobe by one cycle.
  always_comb begin
    almost_empty = '0;
    almost_full  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      almost_empty[c] = (count_q[c] <= ae_thr);
      almost_full[c]  = (count_q[c] >= af_thr);
    end
  end

  assign push       = push_c;
  assign pop        = pop_c;
  assign wr_ptr     = wr_ptr_q;
  assign rd_ptr     = rd_ptr_q;
  assign count      = count_q;
  assign fifo_empty = empty_c;
  assign fifo_full  = full_c;
  assign err_ovf    = err_ovf_q;
  assign err_udf    = err_udf_q;

endmodule

// File: tb/tb_fifo_ctrl_mc.sv
// ---------------------------------------------------------------------------
// tb_fifo_ctrl_mc
//
// Bench for fifo_ctrl_mc. A 4-channel, depth-4 instance is driven cycle by
// cycle; a behavioural model predicts strobes before the edge and the full
// registered state after it (expected state goes through a queue). A second
// single-channel, depth-5 instance covers non-power-of-two wrap.
// ---------------------------------------------------------------------------
module tb_fifo_ctrl_mc;

  localparam int NC = 4;
  localparam int MS = 4;
  localparam int PL = 2;
  localparam int CL = 3;

  logic clk = 1'b0;
  logic reset_L;
  always #5 clk = ~clk;

  logic [NC-1:0]    fifo_wr, fifo_rd;
  logic [CL-1:0]    af_thr, ae_thr;
  logic             err_clr;
  logic [NC-1:0]    push, pop, fifo_empty, fifo_full, almost_empty, almost_full;
  logic [NC-1:0]    err_ovf, err_udf;
  logic [NC*PL-1:0] wr_ptr, rd_ptr;
  logic [NC*CL-1:0] count;

  // depth-5 instance
  logic [0:0] fifo_wr5, fifo_rd5, push5, pop5, empty5, full5, ae5, af5, ovf5, udf5;
  logic [2:0] wr_ptr5, rd_ptr5, count5;

  fifo_ctrl_mc #(.NUM_CH(NC), .MEM_SIZE(MS), .WORD_SIZE(6), .PTR_L(PL), .CNT_L(CL)) u_dut (
    .clk(clk), .reset_L(reset_L), .fifo_wr(fifo_wr), .fifo_rd(fifo_rd),
    .af_thr(af_thr), .ae_thr(ae_thr), .err_clr(err_clr),
    .push(push), .pop(pop), .wr_ptr(wr_ptr), .rd_ptr(rd_ptr), .count(count),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .almost_empty(almost_empty), .almost_full(almost_full),
    .err_ovf(err_ovf), .err_udf(err_udf)
  );

  fifo_ctrl_mc #(.NUM_CH(1), .MEM_SIZE(5), .WORD_SIZE(6), .PTR_L(3), .CNT_L(3)) u_dut5 (
    .clk(clk), .reset_L(reset_L), .fifo_wr(fifo_wr5), .fifo_rd(fifo_rd5),
    .af_thr(af_thr), .ae_thr(ae_thr), .err_clr(err_clr),
    .push(push5), .pop(pop5), .wr_ptr(wr_ptr5), .rd_ptr(rd_ptr5), .count(count5),
    .fifo_empty(empty5), .fifo_full(full5),
    .almost_empty(ae5), .almost_full(af5),
    .err_ovf(ovf5), .err_udf(udf5)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- model and scoreboard ----------------
  typedef struct {
    logic [NC*PL-1:0] wr, rd;
    logic [NC*CL-1:0] cnt;
    logic [NC-1:0]    empty, full, ae, af, ovf, udf;
  } exp_t;

  exp_t sb[$];

  int m_wr[NC], m_rd[NC], m_cnt[NC];
  bit m_ovf[NC], m_udf[NC];

  logic wr5_req = 1'b0;
  logic push5_pre;

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      m_wr[c] = 0; m_rd[c] = 0; m_cnt[c] = 0; m_ovf[c] = 0; m_udf[c] = 0;
    end
    sb.delete();
  endtask

  function automatic exp_t model_snapshot();
    exp_t e;
    e.wr = '0; e.rd = '0; e.cnt = '0;
    e.empty = '0; e.full = '0; e.ae = '0; e.af = '0; e.ovf = '0; e.udf = '0;
    for (int c = 0; c < NC; c++) begin
      e.wr[c*PL +: PL]  = PL'(m_wr[c]);
      e.rd[c*PL +: PL]  = PL'(m_rd[c]);
      e.cnt[c*CL +: CL] = CL'(m_cnt[c]);
      e.empty[c] = (m_cnt[c] == 0);
      e.full[c]  = (m_cnt[c] == MS);
      e.ae[c]    = (m_cnt[c] <= int'(ae_thr));
      e.af[c]    = (m_cnt[c] >= int'(af_thr));
      e.ovf[c]   = m_ovf[c];
      e.udf[c]   = m_udf[c];
    end
    return e;
  endfunction

  // One clock of stimulus: strobes checked before the edge, state after it.
  task automatic step(input logic [NC-1:0] wr, input logic [NC-1:0] rd, input logic clr);
    logic [NC-1:0] ep, eo;
    exp_t e;
    @(negedge clk);
    fifo_wr = wr; fifo_rd = rd; err_clr = clr; fifo_wr5 = wr5_req;
    #1;
    for (int c = 0; c < NC; c++) begin
`ifdef RD_BYPASS_EN
      eo[c] = rd[c] && ((m_cnt[c] != 0) || wr[c]);
`else
      eo[c] = rd[c] && (m_cnt[c] != 0);
`endif
      ep[c] = wr[c] && ((m_cnt[c] != MS) || eo[c]);
    end
    check("push", 32'(push), 32'(ep));
    check("pop",  32'(pop),  32'(eo));
    push5_pre = push5[0];
    for (int c = 0; c < NC; c++) begin
      if (ep[c]) m_wr[c] = (m_wr[c] + 1) % MS;
      if (eo[c]) m_rd[c] = (m_rd[c] + 1) % MS;
      m_cnt[c] = m_cnt[c] + int'(ep[c]) - int'(eo[c]);
      m_ovf[c] = (m_ovf[c] && !clr) || (wr[c] && !ep[c]);
      m_udf[c] = (m_udf[c] && !clr) || (rd[c] && !eo[c]);
    end
    sb.push_back(model_snapshot());
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("wr_ptr",       32'(wr_ptr),       32'(e.wr));
    check("rd_ptr",       32'(rd_ptr),       32'(e.rd));
    check("count",        32'(count),        32'(e.cnt));
    check("fifo_empty",   32'(fifo_empty),   32'(e.empty));
    check("fifo_full",    32'(fifo_full),    32'(e.full));
    check("almost_empty", 32'(almost_empty), 32'(e.ae));
    check("almost_full",  32'(almost_full),  32'(e.af));
    check("err_ovf",      32'(err_ovf),      32'(e.ovf));
    check("err_udf",      32'(err_udf),      32'(e.udf));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int seq5[5] = '{1, 2, 3, 4, 0};

    reset_L = 1'b0;
    fifo_wr = '0; fifo_rd = '0; err_clr = 1'b0;
    fifo_wr5 = '0; fifo_rd5 = '0;
    af_thr = 3'd3; ae_thr = 3'd1;
    model_reset();

    // ---- reset state ----
    #12;
    check("rst_wr_ptr", 32'(wr_ptr), 0);
    check("rst_count",  32'(count),  0);
    check("rst_empty",  32'(fifo_empty), 32'hF);
    check("rst_full",   32'(fifo_full),  0);
    check("rst_ae",     32'(almost_empty), 32'hF);
    check("rst_af",     32'(almost_full),  0);
    check("rst_err",    32'({err_ovf, err_udf}), 0);
    af_thr = 3'd0;
    #1;
    check("rst_af_thr0", 32'(almost_full), 32'hF);
    af_thr = 3'd3;
    @(negedge clk);
    reset_L = 1'b1;

    // ---- ch1: move pointers to 3, fill, then full read+write wraps 3->0 ----
    repeat (3) step(4'b0010, 4'b0000, 1'b0);
    repeat (3) step(4'b0000, 4'b0010, 1'b0);
    repeat (4) step(4'b0010, 4'b0000, 1'b0);
    check("ch1_full_cnt", 32'(count[1*CL +: CL]), 4);
    check("ch1_wr_ptr3",  32'(wr_ptr[1*PL +: PL]), 3);
    step(4'b0010, 4'b0010, 1'b0);
    check("ch1_rw_cnt",   32'(count[1*CL +: CL]), 4);
    check("ch1_rw_wr",    32'(wr_ptr[1*PL +: PL]), 0);
    check("ch1_rw_rd",    32'(rd_ptr[1*PL +: PL]), 0);

    // ---- ch2 thresholds: af_thr=3, ae_thr=1 ----
    step(4'b0100, 4'b0000, 1'b0);
    step(4'b0100, 4'b0000, 1'b0);
    check("ch2_af_at2", 32'(almost_full[2]), 0);
    step(4'b0100, 4'b0000, 1'b0);
    check("ch2_af_at3", 32'(almost_full[2]), 1);
    step(4'b0000, 4'b0100, 1'b0);
    check("ch2_ae_at2", 32'(almost_empty[2]), 0);
    step(4'b0000, 4'b0100, 1'b0);
    check("ch2_ae_at1", 32'(almost_empty[2]), 1);

    // ---- ch3 read+write while empty ----
    step(4'b1000, 4'b1000, 1'b0);
`ifdef RD_BYPASS_EN
    check("ch3_byp_cnt", 32'(count[3*CL +: CL]), 0);
    check("ch3_byp_wr",  32'(wr_ptr[3*PL +: PL]), 1);
    check("ch3_byp_rd",  32'(rd_ptr[3*PL +: PL]), 1);
    check("ch3_byp_udf", 32'(err_udf[3]), 0);
`else
    check("ch3_cnt", 32'(count[3*CL +: CL]), 1);
    check("ch3_wr",  32'(wr_ptr[3*PL +: PL]), 1);
    check("ch3_rd",  32'(rd_ptr[3*PL +: PL]), 0);
    check("ch3_udf", 32'(err_udf[3]), 1);
`endif

    // ---- overflow on full ch1 with err_clr in the same cycle ----
    step(4'b0010, 4'b0000, 1'b1);
    check("ovf_set_wins", 32'(err_ovf[1]), 1);
    step(4'b0000, 4'b0000, 1'b1);
    check("ovf_cleared",  32'(err_ovf), 0);

    // ---- depth-5 channel: wrap 4->0, full, rejected 6th write ----
    wr5_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(4'b0000, 4'b0000, 1'b0);
      check("d5_wr_ptr", 32'(wr_ptr5), 32'(seq5[i]));
    end
    check("d5_count", 32'(count5), 5);
    check("d5_full",  32'(full5), 1);
    step(4'b0000, 4'b0000, 1'b0);
    check("d5_push6", 32'(push5_pre), 0);
    check("d5_ovf",   32'(ovf5), 1);
    check("d5_wr_hold", 32'(wr_ptr5), 0);
    wr5_req = 1'b0;

    // ---- random traffic, two threshold settings ----
    for (int i = 0; i < 300; i++)
      step(4'($urandom), 4'($urandom), ($urandom_range(0, 15) == 0));
    af_thr = 3'd4; ae_thr = 3'd0;
    for (int i = 0; i < 300; i++)
      step(4'($urandom), 4'($urandom), ($urandom_range(0, 15) == 0));

    // ---- reset mid-burst ----
    step(4'hF, 4'h0, 1'b0);
    @(negedge clk);
    fifo_wr = 4'hF; fifo_rd = 4'h0;
    reset_L = 1'b0;
    #1;
    check("midrst_wr_ptr", 32'(wr_ptr), 0);
    check("midrst_rd_ptr", 32'(rd_ptr), 0);
    check("midrst_count",  32'(count),  0);
    check("midrst_push",   32'(push),   0);
    check("midrst_empty",  32'(fifo_empty), 32'hF);
    model_reset();
    @(negedge clk);
    fifo_wr = '0;
    reset_L = 1'b1;
    step(4'h0, 4'h0, 1'b0);
    step(4'h5, 4'h0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
